light_conflict_monitor: RTL
===========================

# light_conflict_monitor

Fail-safe supervisor placed directly downstream of the T-intersection traffic controller, between its six lamp outputs and the physical lamp drivers. It passes legal lamp patterns through with a one-cycle register delay. It detects conflicting or malformed patterns and illegal phase sequences. On any fault it latches a fault code and forces both approaches to red (flashing or steady) until reset.

## Interface
- `STARTUP_CYC`, default 16: cycles of forced all-red after reset before monitoring begins (≥1).
- `MIN_YELLOW`, default 100_000_000: minimum consecutive cycles a yellow must be held.
- `FILTER_CYC`, default 4: consecutive cycles a static violation must persist before it latches a fault (≥1).
- `FLASH_HALF`, default 25_000_000: half-period of the fault flash, in cycles.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `main_red`, `main_yellow`, `main_green` in 1 each: main-road lamp requests from the controller.
- `side_red`, `side_yellow`, `side_green` in 1 each: side-road lamp requests from the controller.
- `lamp_main_red`, `lamp_main_yellow`, `lamp_main_green` out 1 each: main-road lamp drive.
- `lamp_side_red`, `lamp_side_yellow`, `lamp_side_green` out 1 each: side-road lamp drive.
- `fault` out 1: latched fault flag.
- `fault_code` out 3: latched cause of the first fault; 0 means none.

## Operation
- **Input stage.** All six inputs are registered into `in_q` every cycle. `prev_q` holds the previous `in_q` value.
- **States.**
  - `STARTUP`: the counter runs 0..STARTUP_CYC-1. Then go to `MONITOR`. All checks are disabled.
  - `MONITOR`: lamp outputs equal `in_q`. Checks are active.
  - `FAULT`: absorbing. Only `reset` exits this state.
- **Static checks** are evaluated on `in_q`:
  - code 1, conflict: both approaches are non-red at the same time (any of yellow/green set on both).
  - code 2: main approach is not one-hot (none set, or more than one set).
  - code 3: side approach is not one-hot (none set, or more than one set).
- **Static filter.** A static violation increments `viol_cnt`. When it is absent, `viol_cnt` clears to 0. The fault latches when a violation is present and `viol_cnt == FILTER_CYC-1`.
- **Transition checks** are evaluated on `prev_q` to `in_q`, per approach. They latch immediately, with no filter.
  - code 4: green goes directly to red.
  - code 5: yellow deasserts after fewer than MIN_YELLOW consecutive asserted cycles.
- **Yellow counter.** One per approach. It counts consecutive `in_q` yellow cycles, saturates at MIN_YELLOW, and clears when yellow is low.
- **Priority.** If several violations latch in the same cycle, the lowest code wins. Main is checked before side within codes 4 and 5.
- **Latched fault.** `fault_code` records the first fault only and never changes afterwards.
- **Fault outputs.** In `FAULT`, all yellow and green outputs are 0, and red behaviour follows Configuration.
- **Mid-operation reset.** A reset from any state returns the block to `STARTUP`, applies the reset values, and clears all counters and `prev_q`.

## Timing
- **Reset values.**
  - Lamp outputs: `lamp_main_red`=1, `lamp_side_red`=1, all others 0.
  - Status: `fault`=0, `fault_code`=0.
  - Internal: state `STARTUP`, flash phase ON.
  - Registers: `in_q` and `prev_q` hold the all-red pattern; `viol_cnt` and both yellow counters are 0.
- **Startup timing.** The first `MONITOR` cycle is cycle STARTUP_CYC after reset deasserts. During that cycle the transition checks compare against `prev_q`, which was loaded during `STARTUP`.
- **Pass-through latency.** In `MONITOR`, a change on an input reaches the lamp outputs 2 edges later: input register, then output register.
- **Fault latch timing.** A fault latches on the edge where its condition holds. On that same edge `fault` and `fault_code` are set and the outputs switch to the fault pattern.
- **Code 1 latency.** A conflict held from input edge n latches on edge n+FILTER_CYC.

## Configuration
- `LCM_FLASH_EN` defined: in `FAULT`, both red outputs toggle together every FLASH_HALF cycles. They start ON on the latch edge, giving a period of 2·FLASH_HALF.
- `LCM_FLASH_EN` undefined: in `FAULT`, both red outputs are held at a steady 1. The flash counter is not instantiated.

## Structure
- **Package `lcm_pkg`:**
  - state enum `lcm_state_t` with values `STARTUP`, `MONITOR`, `FAULT`.
  - fault-code enum `lcm_fault_t` with values `NONE`=0, `CONFLICT`=1, `MAIN_HOT`=2, `SIDE_HOT`=3, `GREEN_SKIP`=4, `YELLOW_SHORT`=5.
  - a packed lamp struct holding red, yellow and green.
- **Sub-module `lcm_yellow_timer`:** one instance per approach. It holds the saturating counter and produces the short-yellow pulse.

## Test plan
All scenarios use STARTUP_CYC=4, MIN_YELLOW=3, FILTER_CYC=2, FLASH_HALF=5.

- **Startup:** reset, then drive main green / side red → lamp outputs stay all-red through cycle 3. Main green appears at the outputs 2 edges after `MONITOR` is entered. `fault`=0.
- **Legal sequence:** main G→Y(3 cycles)→R, then side R→G, over the same cycles → no fault; the outputs mirror the inputs delayed by 2 cycles.
- **Conflict:** main green and side green held → `fault_code`=1 exactly 2 edges after `in_q` first shows the conflict. A 1-cycle conflict glitch → no fault.
- **Sequence violations:**
  - main yellow held 2 cycles, then red → `fault_code`=5.
  - separately, side green goes directly to red → `fault_code`=4.
- **Simultaneous faults:** side all-zero together with main green→red on the same edge → `fault_code`=4, because codes 4 and 3 differ in filtering. Persisting the violation afterwards does not change the code.
- **Fault outputs and recovery:**
  - with `LCM_FLASH_EN`: reds read 1 for 5 cycles, 0 for 5, 1 for 5.
  - without `LCM_FLASH_EN`: reds read a steady 1.
  - a mid-FAULT reset → `fault`=0 and state returns to `STARTUP`.

Source files
------------

// File: rtl/lcm_pkg.sv
// Shared types for the light conflict monitor: FSM states, fault codes and lamp structs.
package lcm_pkg;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } lcm_state_t;

  typedef enum logic [2:0] {
    NONE         = 3'd0,
    CONFLICT     = 3'd1,
    MAIN_HOT     = 3'd2,
    SIDE_HOT     = 3'd3,
    GREEN_SKIP   = 3'd4,
    YELLOW_SHORT = 3'd5
  } lcm_fault_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  typedef struct packed {
    lamp_t main;
    lamp_t side;
  } lamp_pair_t;

  localparam lamp_pair_t RED_PAIR = 6'b100_100;

  function automatic logic lamp_one_hot(input lamp_t l);
    return (l.red ^ l.yellow ^ l.green) & ~(l.red & l.yellow & l.green);
  endfunction

  function automatic logic lamp_go(input lamp_t l);
    return l.yellow | l.green;
  endfunction

endpackage

// File: rtl/lcm_yellow_timer.sv
// Per-approach yellow run-length counter; flags a yellow that ends before MIN_YELLOW cycles.
module lcm_yellow_timer #(
  parameter int unsigned MIN_YELLOW = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic yellow_i,
  input  logic yellow_prev_i,
  output logic short_o
);

  localparam int unsigned CNT_W = $clog2(MIN_YELLOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_YELLOW);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (yellow_i) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q holds the run length ending on the previous in_q cycle
  assign short_o = yellow_prev_i & ~yellow_i & (cnt_q < CNT_MAX);

endmodule

// File: rtl/light_conflict_monitor.sv
// Fail-safe lamp supervisor: registered pass-through with conflict/sequence checks and latched fault.
// Define LCM_FLASH_EN to flash the reds in FAULT; otherwise the reds are held steady on.
module light_conflict_monitor
  import lcm_pkg::*;
#(
  parameter int unsigned STARTUP_CYC = 16,
  parameter int unsigned MIN_YELLOW  = 100_000_000,
  parameter int unsigned FILTER_CYC  = 4,
  parameter int unsigned FLASH_HALF  = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       main_red,
  input  logic       main_yellow,
  input  logic       main_green,
  input  logic       side_red,
  input  logic       side_yellow,
  input  logic       side_green,
  output logic       lamp_main_red,
  output logic       lamp_main_yellow,
  output logic       lamp_main_green,
  output logic       lamp_side_red,
  output logic       lamp_side_yellow,
  output logic       lamp_side_green,
  output logic       fault,
  output logic [2:0] fault_code
);

  if (STARTUP_CYC < 1 || FILTER_CYC < 1 || MIN_YELLOW < 1 || FLASH_HALF < 1) begin : g_bad_param
    $error("light_conflict_monitor: all cycle parameters must be >= 1");
  end

  localparam int unsigned ST_W = $clog2(STARTUP_CYC + 1);
  localparam int unsigned FC_W = $clog2(FILTER_CYC + 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STARTUP_CYC - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYC - 1);

  lcm_state_t      state_q, state_d;
  lcm_fault_t      code_q, code_d, latch_code;
  lamp_pair_t      in_d, in_q, prev_q, out_q, out_d;
  logic [ST_W-1:0] st_cnt_q, st_cnt_d;
  logic [FC_W-1:0] viol_cnt_q, viol_cnt_d;
  logic            fault_q, fault_d;
  logic            conflict, main_bad, side_bad, viol;
  logic            skip_main, skip_side, short_main, short_side;
  logic            flash_red;

  assign in_d = {main_red, main_yellow, main_green, side_red, side_yellow, side_green};

  lcm_yellow_timer #(.MIN_YELLOW(MIN_YELLOW)) u_yel_main (
    .clk           (clk),
    .reset         (reset),
    .yellow_i      (in_q.main.yellow),
    .yellow_prev_i (prev_q.main.yellow),
    .short_o       (short_main)
  );

  lcm_yellow_timer #(.MIN_YELLOW(MIN_YELLOW)) u_yel_side (
    .clk           (clk),
    .reset         (reset),
    .yellow_i      (in_q.side.yellow),
    .yellow_prev_i (prev_q.side.yellow),
    .short_o       (short_side)
  );

  assign conflict  = lamp_go(in_q.main) & lamp_go(in_q.side);
  assign main_bad  = ~lamp_one_hot(in_q.main);
  assign side_bad  = ~lamp_one_hot(in_q.side);
  assign viol      = conflict | main_bad | side_bad;
  // A lamp showing green (not red) that now shows red (not green) skipped its yellow
  assign skip_main = prev_q.main.green & ~prev_q.main.red & in_q.main.red & ~in_q.main.green;
  assign skip_side = prev_q.side.green & ~prev_q.side.red & in_q.side.red & ~in_q.side.green;

  always_comb begin
    latch_code = NONE;
    if (viol && viol_cnt_q == FC_LAST)
      latch_code = conflict ? CONFLICT : (main_bad ? MAIN_HOT : SIDE_HOT);
    else if (skip_main || skip_side)
      latch_code = GREEN_SKIP;
    else if (short_main || short_side)
      latch_code = YELLOW_SHORT;
  end

`ifdef LCM_FLASH_EN
  localparam int unsigned FL_W = $clog2(FLASH_HALF + 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_HALF - 1);

  logic [FL_W-1:0] flash_cnt_q, flash_cnt_d;
  logic            flash_on_q, flash_on_d;

  // Phase sits at ON with a cleared count until FAULT, so the flash starts ON at the latch edge
  always_comb begin
    flash_on_d  = flash_on_q;
    flash_cnt_d = flash_cnt_q;
    if (state_q != FAULT) begin
      flash_on_d  = 1'b1;
      flash_cnt_d = '0;
    end else if (flash_cnt_q == FL_LAST) begin
      flash_on_d  = ~flash_on_q;
      flash_cnt_d = '0;
    end else begin
      flash_cnt_d = flash_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_on_q  <= 1'b1;
      flash_cnt_q <= '0;
    end else begin
      flash_on_q  <= flash_on_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign flash_red = flash_on_d;
`else
  assign flash_red = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    st_cnt_d   = st_cnt_q;
    viol_cnt_d = '0;
    fault_d    = fault_q;
    code_d     = code_q;
    out_d      = out_q;
    unique case (state_q)
      STARTUP: begin
        out_d = RED_PAIR;
        if (st_cnt_q == ST_LAST) begin
          state_d  = MONITOR;
          st_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + 1'b1;
        end
      end
      MONITOR: begin
        if (latch_code != NONE) begin
          state_d = FAULT;
          fault_d = 1'b1;
          code_d  = latch_code;
          out_d   = RED_PAIR;
        end else begin
          out_d = in_q;
          if (viol) viol_cnt_d = viol_cnt_q + 1'b1;
        end
      end
      FAULT: begin
        out_d          = '0;
        out_d.main.red = flash_red;
        out_d.side.red = flash_red;
      end
      default: state_d = STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STARTUP;
      st_cnt_q   <= '0;
      viol_cnt_q <= '0;
      fault_q    <= 1'b0;
      code_q     <= NONE;
      out_q      <= RED_PAIR;
      in_q       <= RED_PAIR;
      prev_q     <= RED_PAIR;
    end else begin
      state_q    <= state_d;
      st_cnt_q   <= st_cnt_d;
      viol_cnt_q <= viol_cnt_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
      out_q      <= out_d;
      in_q       <= in_d;
      prev_q     <= in_q;
    end
  end

  assign lamp_main_red    = out_q.main.red;
  assign lamp_main_yellow = out_q.main.yellow;
  assign lamp_main_green  = out_q.main.green;
  assign lamp_side_red    = out_q.side.red;
  assign lamp_side_yellow = out_q.side.yellow;
  assign lamp_side_green  = out_q.side.green;
  assign fault            = fault_q;
  assign fault_code       = code_q;

endmodule
